// File: rtl/rt_pkg.sv
// Shared types, defaults and fixed-point helpers for the sequential ray tracer blocks.
package rt_pkg;

    localparam int unsigned RT_Q_BITS  = 10;
    localparam int unsigned RT_D_WIDTH = 32;

    typedef logic signed [0:2][RT_D_WIDTH-1:0] vec3_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DOT,
        ST_DIV,
        ST_SCALE,
        ST_OUT
    } rpi_state_t;

    // Full-width signed product, arithmetic shift by the fractional bits, truncate.
    function automatic logic [RT_D_WIDTH-1:0] fx_mul(
        input logic [RT_D_WIDTH-1:0] a,
        input logic [RT_D_WIDTH-1:0] b,
        input int unsigned           shift
    );
        logic signed [2*RT_D_WIDTH-1:0] p;
        p = $signed({{RT_D_WIDTH{a[RT_D_WIDTH-1]}}, a}) *
            $signed({{RT_D_WIDTH{b[RT_D_WIDTH-1]}}, b});
        return RT_D_WIDTH'(p >>> shift);
    endfunction

endpackage

// File: rtl/rt_seq_divide.sv
// Iterative signed restoring divider: quo = (num << Q_BITS) / den, truncated toward
// zero and saturated to +/-(2^(D_WIDTH-1)-1). One quotient bit per cycle.
// done_c is high during the cycle whose closing edge produces the final quotient.
module rt_seq_divide #(
    parameter int unsigned Q_BITS  = 10,
    parameter int unsigned D_WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [D_WIDTH-1:0] num,
    input  logic [D_WIDTH-1:0] den,
    output logic               busy,
    output logic               done_c,
    output logic [D_WIDTH-1:0] quo
);

    localparam int unsigned N  = D_WIDTH + Q_BITS;
    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [N-1:0] SAT_MAG = N'({1'b0, {(D_WIDTH-1){1'b1}}});

    logic [CW-1:0]      cnt;
    logic [N-1:0]       dvd;
    logic [N-1:0]       qmag;
    logic [D_WIDTH-1:0] rem;
    logic [D_WIDTH-1:0] dsr;
    logic               neg;

    logic [D_WIDTH-1:0] num_mag, den_mag, rem_nx, mag, res;
    logic [D_WIDTH:0]   rem_sh;
    logic [N-1:0]       q_nx;
    logic               ge;

    // Operand magnitudes, one restoring step, and saturated signed result.
    always_comb begin
        num_mag = num[D_WIDTH-1] ? (D_WIDTH'(0) - num) : num;
        den_mag = den[D_WIDTH-1] ? (D_WIDTH'(0) - den) : den;
        rem_sh  = {rem, dvd[N-1]};
        ge      = (rem_sh >= {1'b0, dsr});
        rem_nx  = ge ? D_WIDTH'(rem_sh - {1'b0, dsr}) : rem_sh[D_WIDTH-1:0];
        q_nx    = {qmag[N-2:0], ge};
        mag     = (q_nx > SAT_MAG) ? SAT_MAG[D_WIDTH-1:0] : q_nx[D_WIDTH-1:0];
        res     = neg ? (D_WIDTH'(0) - mag) : mag;
        done_c  = busy && (cnt == CW'(N - 1));
    end

    // Load on start, then shift/subtract until the last quotient bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            dvd  <= '0;
            qmag <= '0;
            rem  <= '0;
            dsr  <= '0;
            neg  <= 1'b0;
            quo  <= '0;
        end else if (busy) begin
            rem  <= rem_nx;
            qmag <= q_nx;
            dvd  <= dvd << 1;
            cnt  <= cnt + CW'(1);
            if (done_c) begin
                busy <= 1'b0;
                quo  <= res;
            end
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            dvd  <= N'(num_mag) << Q_BITS;
            qmag <= '0;
            rem  <= '0;
            dsr  <= den_mag;
            neg  <= num[D_WIDTH-1] ^ den[D_WIDTH-1];
        end
    end

endmodule

// File: rtl/ray_plane_intersect_seq.sv
// Sequential ray/plane intersection: t = (n.v0 - n.origin)/(n.dir), p_hit = origin + t*dir.
// Optional feature macro: RPI_BACKFACE_CULL_EN (rays travelling along the normal report no hit).
module ray_plane_intersect_seq
    import rt_pkg::*;
#(
    parameter int unsigned Q_BITS  = RT_Q_BITS,
    parameter int unsigned D_WIDTH = RT_D_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [0:2][D_WIDTH-1:0] normal,
    input  logic [0:2][D_WIDTH-1:0] v0,
    input  logic [0:2][D_WIDTH-1:0] origin,
    input  logic [0:2][D_WIDTH-1:0] dir,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [0:2][D_WIDTH-1:0] p_hit,
    output logic [D_WIDTH-1:0]      t_hit,
    output logic                    hit
);

    rpi_state_t state, state_nx;

    vec3_t n_r, v0_r, o_r, d_r;

    logic [D_WIDTH-1:0] nv0_c, no_c, nd_c, num_c, den_c;
    logic [D_WIDTH-1:0] div_quo;
    logic               div_busy, div_done_c, div_start_c;

`ifdef RPI_BACKFACE_CULL_EN
    logic den_neg_r;
`endif

    // Dot products of the captured ray against the plane normal.
    always_comb begin
        nv0_c = fx_mul(n_r[0], v0_r[0], Q_BITS) + fx_mul(n_r[1], v0_r[1], Q_BITS) +
                fx_mul(n_r[2], v0_r[2], Q_BITS);
        no_c  = fx_mul(n_r[0], o_r[0], Q_BITS) + fx_mul(n_r[1], o_r[1], Q_BITS) +
                fx_mul(n_r[2], o_r[2], Q_BITS);
        nd_c  = fx_mul(n_r[0], d_r[0], Q_BITS) + fx_mul(n_r[1], d_r[1], Q_BITS) +
                fx_mul(n_r[2], d_r[2], Q_BITS);
        num_c = nv0_c - no_c;
        den_c = nd_c;
        div_start_c = (state == ST_DOT) && (den_c != '0) && !div_busy;
    end

    rt_seq_divide #(
        .Q_BITS  (Q_BITS),
        .D_WIDTH (D_WIDTH)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .start  (div_start_c),
        .num    (num_c),
        .den    (den_c),
        .busy   (div_busy),
        .done_c (div_done_c),
        .quo    (div_quo)
    );

    // State register with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            ready_in  <= 1'b1;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nx;
            ready_in  <= (state_nx == ST_IDLE);
            valid_out <= (state_nx == ST_OUT);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (valid_in && ready_in) state_nx = ST_DOT;
            ST_DOT:   state_nx = (den_c == '0) ? ST_OUT : ST_DIV;
            ST_DIV:   if (div_done_c) state_nx = ST_SCALE;
            ST_SCALE: state_nx = ST_OUT;
            ST_OUT:   if (ready_out) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Operand capture and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_r   <= '0;
            v0_r  <= '0;
            o_r   <= '0;
            d_r   <= '0;
            p_hit <= '0;
            t_hit <= '0;
            hit   <= 1'b0;
`ifdef RPI_BACKFACE_CULL_EN
            den_neg_r <= 1'b0;
`endif
        end else begin
            if (state == ST_IDLE && valid_in && ready_in) begin
                n_r  <= normal;
                v0_r <= v0;
                o_r  <= origin;
                d_r  <= dir;
            end
            if (state == ST_DOT) begin
`ifdef RPI_BACKFACE_CULL_EN
                den_neg_r <= den_c[D_WIDTH-1];
`endif
                if (den_c == '0) begin
                    p_hit <= '0;
                    t_hit <= '0;
                    hit   <= 1'b0;
                end
            end
            if (state == ST_SCALE) begin
                for (int i = 0; i < 3; i++) begin
                    p_hit[i] <= o_r[i] + fx_mul(d_r[i], div_quo, Q_BITS);
                end
                t_hit <= div_quo;
`ifdef RPI_BACKFACE_CULL_EN
                hit <= !div_quo[D_WIDTH-1] && den_neg_r;
`else
                hit <= !div_quo[D_WIDTH-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ray_plane_intersect_seq.sv
// Self-checking bench for ray_plane_intersect_seq: directed plan cases plus random rays
// compared against an arithmetic reference model.
module tb_ray_plane_intersect_seq;

    localparam int Q = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              valid_in = 1'b0;
    logic              ready_out = 1'b1;
    logic              ready_in, valid_out, hit;
    logic [0:2][31:0]  normal = '0, v0 = '0, origin = '0, dir = '0;
    logic [0:2][31:0]  p_hit;
    logic [31:0]       t_hit;

    int n_checks = 0;
    int n_fail   = 0;

    int rn[3], rv[3], ro[3], rd[3];
    int e_t, e_p[3], e_lat;
    logic e_hit;
    int lat;

    always #5 clock = ~clock;

    ray_plane_intersect_seq dut (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .normal    (normal),
        .v0        (v0),
        .origin    (origin),
        .dir       (dir),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .p_hit     (p_hit),
        .t_hit     (t_hit),
        .hit       (hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int fxm(int a, int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> Q);
    endfunction

    // Reference: straight arithmetic on the plane equation with 64-bit division.
    task automatic model();
        int nv0, no, nd, num;
        longint an, ad, q;
        nv0 = fxm(rn[0], rv[0]) + fxm(rn[1], rv[1]) + fxm(rn[2], rv[2]);
        no  = fxm(rn[0], ro[0]) + fxm(rn[1], ro[1]) + fxm(rn[2], ro[2]);
        nd  = fxm(rn[0], rd[0]) + fxm(rn[1], rd[1]) + fxm(rn[2], rd[2]);
        num = nv0 - no;
        if (nd == 0) begin
            e_t = 0; e_p[0] = 0; e_p[1] = 0; e_p[2] = 0; e_hit = 1'b0; e_lat = 2;
        end else begin
            an = (num < 0) ? -longint'(num) : longint'(num);
            ad = (nd < 0) ? -longint'(nd) : longint'(nd);
            q  = (an << Q) / ad;
            if (q > 64'sd2147483647) q = 64'sd2147483647;
            e_t = ((num < 0) != (nd < 0)) ? int'(-q) : int'(q);
            for (int i = 0; i < 3; i++) e_p[i] = ro[i] + fxm(rd[i], e_t);
            e_hit = (e_t >= 0);
`ifdef RPI_BACKFACE_CULL_EN
            e_hit = e_hit && (nd < 0);
`endif
            e_lat = 45;
        end
    endtask

    task automatic set_ray(input int n0, n1, n2, input int a0, a1, a2,
                           input int o0, o1, o2, input int d0, d1, d2);
        rn[0] = n0; rn[1] = n1; rn[2] = n2;
        rv[0] = a0; rv[1] = a1; rv[2] = a2;
        ro[0] = o0; ro[1] = o1; ro[2] = o2;
        rd[0] = d0; rd[1] = d1; rd[2] = d2;
    endtask

    task automatic set_exp(input int t, p0, p1, p2, input logic h, input int l);
        e_t = t; e_p[0] = p0; e_p[1] = p1; e_p[2] = p2; e_hit = h; e_lat = l;
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            normal[i] = rn[i]; v0[i] = rv[i]; origin[i] = ro[i]; dir[i] = rd[i];
        end
    endtask

    // Present a request at a negedge; it is accepted on the following posedge.
    task automatic request();
        drive();
        valid_in = 1'b1;
        check("ready_before_accept", 32'(ready_in), 32'd1);
        @(posedge clock);
        @(negedge clock);
        valid_in = 1'b0;
    endtask

    // Latency = number of edges from accept to the first edge with valid_out high.
    task automatic wait_result(output int l);
        int cnt;
        cnt = 0;
        l = -1;
        for (int i = 0; i < 200; i++) begin
            if (valid_out) begin
                l = cnt + 1;
                break;
            end
            @(posedge clock);
            cnt++;
            @(negedge clock);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_t"},  t_hit, e_t);
        check({tag, "_p0"}, p_hit[0], e_p[0]);
        check({tag, "_p1"}, p_hit[1], e_p[1]);
        check({tag, "_p2"}, p_hit[2], e_p[2]);
        check({tag, "_hit"}, 32'(hit), 32'(e_hit));
    endtask

    task automatic consume();
        ready_out = 1'b1;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_ray(input string tag, input int hold);
        ready_out = (hold == 0);
        request();
        wait_result(lat);
        check({tag, "_lat"}, lat, e_lat);
        check_outputs(tag);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            check({tag, "_hold_valid"}, 32'(valid_out), 32'd1);
            check({tag, "_hold_ready_in"}, 32'(ready_in), 32'd0);
            check_outputs({tag, "_hold"});
        end
        consume();
    endtask

    function automatic int rcomp();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 8191)) - 4096;
            1:       return int'($urandom_range(0, 2097151)) - 1048576;
            2:       return int'($urandom);
            default: return 0;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready_in", 32'(ready_in), 32'd1);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_t", t_hit, 32'd0);
        check("rst_p0", p_hit[0], 32'd0);
        check("rst_p1", p_hit[1], 32'd0);
        check("rst_p2", p_hit[2], 32'd0);
        reset = 1'b0;

        set_ray(0, 0, -1024, 0, 0, 5120, 0, 0, 0, 0, 0, 1024);
        set_exp(5120, 0, 0, 5120, 1'b1, 45);
        run_ray("front", 0);

        set_ray(0, 0, -1024, 0, 0, 5120, 0, 0, 0, 1024, 0, 0);
        set_exp(0, 0, 0, 0, 1'b0, 2);
        run_ray("parallel", 0);

        set_ray(0, 0, -1024, 0, 0, 5120, 0, 0, 10240, 0, 0, 1024);
        set_exp(-5120, 0, 0, 5120, 1'b0, 45);
        run_ray("behind", 0);

        set_ray(0, 0, 1024, 0, 0, 5120, 0, 0, 0, 0, 0, 1024);
`ifdef RPI_BACKFACE_CULL_EN
        set_exp(5120, 0, 0, 5120, 1'b0, 45);
`else
        set_exp(5120, 0, 0, 5120, 1'b1, 45);
`endif
        run_ray("backface", 0);

        // Backpressure for 10 cycles, then a queued request right behind the handshake.
        set_ray(0, 0, -1024, 0, 0, 5120, 0, 0, 0, 0, 0, 1024);
        set_exp(5120, 0, 0, 5120, 1'b1, 45);
        ready_out = 1'b0;
        request();
        wait_result(lat);
        check("bp_lat", lat, e_lat);
        check_outputs("bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            @(negedge clock);
            check("bp_hold_valid", 32'(valid_out), 32'd1);
            check("bp_hold_ready_in", 32'(ready_in), 32'd0);
            check_outputs("bp_hold");
        end
        set_ray(0, 0, -1024, 0, 0, 5120, 0, 0, 10240, 0, 0, 1024);
        drive();
        valid_in  = 1'b1;
        ready_out = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp_after_hs_ready_in", 32'(ready_in), 32'd1);
        check("bp_after_hs_valid", 32'(valid_out), 32'd0);
        @(posedge clock);
        @(negedge clock);
        valid_in = 1'b0;
        check("bp_second_accepted", 32'(ready_in), 32'd0);
        set_exp(-5120, 0, 0, 5120, 1'b0, 45);
        wait_result(lat);
        check("bp2_lat", lat, e_lat);
        check_outputs("bp2");
        consume();

        // Reset while the divider is running.
        set_ray(0, 0, -1024, 0, 0, 5120, 0, 0, 0, 0, 0, 1024);
        ready_out = 1'b1;
        request();
        repeat (19) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_ready_in", 32'(ready_in), 32'd1);
        check("mid_rst_valid", 32'(valid_out), 32'd0);
        check("mid_rst_hit", 32'(hit), 32'd0);
        check("mid_rst_t", t_hit, 32'd0);
        check("mid_rst_p0", p_hit[0], 32'd0);
        check("mid_rst_p1", p_hit[1], 32'd0);
        check("mid_rst_p2", p_hit[2], 32'd0);
        reset = 1'b0;
        set_exp(5120, 0, 0, 5120, 1'b1, 45);
        run_ray("after_rst", 0);

        // Random rays against the reference model, some parallel, some back-pressured.
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 3; i++) begin
                rn[i] = rcomp(); rv[i] = rcomp(); ro[i] = rcomp(); rd[i] = rcomp();
            end
            if ($urandom_range(0, 5) == 0) begin
                rd[0] = 0; rd[1] = 0; rd[2] = 0;
            end
            model();
            run_ray("rand", int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
